// File: rtl/uart_autobaud_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_autobaud_ctrl
// Brief   : Measures a 0x55 sync character on the raw RX line and programs
//           the uart_rx bit-period prescaler. Optional macro
//           AUTOBAUD_VERIFY_EN adds an edge-interval consistency check.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_autobaud_ctrl #(
  parameter int          MIN_DIV = 16,
  parameter logic [11:0] DEF_DIV = 12'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        rx_i,
  output logic        cfg_en_o,
  output logic [11:0] cfg_div_o,
  output logic        lock_o,
  output logic        err_o
);

  localparam logic [14:0] C_CNT_MAX = 15'h7FFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_MEASURE   = 3'd2,
    S_CALC      = 3'd3,
    S_WAIT_STOP = 3'd4,
    S_LOCKED    = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rx_q;
  logic        w_fall;
  logic        w_rise;
  logic [14:0] r_cnt;
  logic [14:0] r_total;
  logic [2:0]  r_edges;
  logic [11:0] r_cfg_div;
  logic        w_cnt_sat;
  logic [12:0] w_div;
  logic        w_div_bad;
  logic        w_ivl_bad;

  assign w_fall    = r_rx_q & ~rx_i;
  assign w_rise    = ~r_rx_q & rx_i;
  assign w_cnt_sat = (r_cnt == C_CNT_MAX);

  // Eight bit times measured, so divide by 8 with round-to-nearest.
  assign w_div     = 13'(({1'b0, r_total} + 16'd4) >> 3);
  assign w_div_bad = (w_div < 13'(MIN_DIV)) || (w_div > 13'd4095);

`ifdef AUTOBAUD_VERIFY_EN
  logic [14:0] r_last;
  logic [14:0] r_ivl [4];
  logic [14:0] w_lo;
  logic [14:0] w_hi;
  logic [3:0]  w_ivl_out;
  logic [1:0]  w_ivl_idx;

  assign w_lo      = (r_total >> 2) - (r_total >> 4);
  assign w_hi      = (r_total >> 2) + (r_total >> 4);
  assign w_ivl_idx = 2'(r_edges - 3'd1);

  // Edge 1 is the time origin, so the distance to edge k is r_cnt itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= '0;
      for (int k = 0; k < 4; k++) r_ivl[k] <= '0;
    end else if (r_state == S_ARM && w_fall) begin
      r_last <= '0;
    end else if (r_state == S_MEASURE && w_fall) begin
      r_ivl[w_ivl_idx] <= r_cnt - r_last;
      r_last           <= r_cnt;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ivl
    assign w_ivl_out[k] = (r_ivl[k] < w_lo) || (r_ivl[k] > w_hi);
  end

  assign w_ivl_bad = |w_ivl_out;
`else
  assign w_ivl_bad = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      w_state_nxt = S_ARM;
        S_ARM:       if (w_fall) w_state_nxt = S_MEASURE;
        S_MEASURE: begin
          if (w_fall && r_edges == 3'd4) w_state_nxt = S_CALC;
          else if (w_cnt_sat)            w_state_nxt = S_ERROR;
        end
        S_CALC:      w_state_nxt = (w_div_bad || w_ivl_bad) ? S_ERROR : S_WAIT_STOP;
        S_WAIT_STOP: begin
          if (w_rise)         w_state_nxt = S_LOCKED;
          else if (w_cnt_sat) w_state_nxt = S_ERROR;
        end
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_q    <= 1'b0;
      r_cnt     <= '0;
      r_edges   <= '0;
      r_total   <= '0;
      r_cfg_div <= DEF_DIV;
    end else begin
      r_rx_q <= rx_i;
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_edges <= '0;
        end
        S_ARM: begin
          if (w_fall) begin
            r_cnt   <= 15'd1;
            r_edges <= 3'd1;
          end
        end
        S_MEASURE: begin
          if (!w_cnt_sat) r_cnt <= r_cnt + 15'd1;
          if (w_fall) begin
            r_edges <= r_edges + 3'd1;
            if (r_edges == 3'd4) r_total <= r_cnt;
          end
        end
        S_CALC: begin
          if (!w_cnt_sat) r_cnt <= r_cnt + 15'd1;
          if (en_i && !w_div_bad && !w_ivl_bad) r_cfg_div <= w_div[11:0];
        end
        S_WAIT_STOP: begin
          if (!w_cnt_sat) r_cnt <= r_cnt + 15'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign cfg_div_o = r_cfg_div;
  assign cfg_en_o  = (r_state == S_LOCKED);
  assign lock_o    = (r_state == S_LOCKED);
  assign err_o     = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_uart_autobaud_ctrl
// Brief   : Vector table of sync frames plus hand sequences for reset-low,
//           lock latency and counter saturation; results via scoreboard.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_autobaud_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        rx_i;
  logic        cfg_en_o;
  logic [11:0] cfg_div_o;
  logic        lock_o;
  logic        err_o;

  uart_autobaud_ctrl #(
    .MIN_DIV (16),
    .DEF_DIV (12'd868)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .rx_i      (rx_i),
    .cfg_en_o  (cfg_en_o),
    .cfg_div_o (cfg_div_o),
    .lock_o    (lock_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bit_clks;
    logic [7:0]  ch;
    bit          extra;
    bit          exp_lock;
    bit          exp_err;
    logic [11:0] exp_div;
  } vec_t;

  typedef struct {
    bit          lock;
    bit          err;
    logic [11:0] div;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   prev_out = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: a result is produced when lock_o or err_o first rises.
  always @(negedge clk) begin
    if (!rst_i) begin
      if ((lock_o || err_o) && !prev_out) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", {30'd0, lock_o, err_o}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_lock",   32'(lock_o),    32'(e.lock));
          check("sb_err",    32'(err_o),     32'(e.err));
          check("sb_cfg_en", 32'(cfg_en_o),  32'(e.lock));
          check("sb_div",    32'(cfg_div_o), 32'(e.div));
        end
      end
      prev_out <= lock_o || err_o;
    end
  end

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic final_rise(input int bc, input bit chk);
    if (chk) check("lock_before_rise", 32'(lock_o), 32'd0);
    rx_i = 1'b1;
    @(negedge clk);
    if (chk) begin
      check("lock_after_rise",   32'(lock_o),   32'd1);
      check("cfg_en_after_rise", 32'(cfg_en_o), 32'd1);
    end
    repeat (bc - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int bc, input logic [7:0] ch, input bit extra, input bit chk);
    hold(1'b0, bc);
    for (int i = 0; i < 8; i++) hold(ch[i], bc);
    if (extra) begin
      hold(1'b1, bc);
      hold(1'b0, bc);
    end
    final_rise(bc, chk);
    hold(1'b1, 4);
  endtask

  task automatic wait_sb(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] prev_div;

    vecs[0] = '{100,  8'h55, 1'b0, 1'b1, 1'b0, 12'd100};
    vecs[1] = '{8,    8'h55, 1'b0, 1'b0, 1'b1, 12'd100};
    vecs[2] = '{15,   8'h55, 1'b0, 1'b0, 1'b1, 12'd100};
`ifdef AUTOBAUD_VERIFY_EN
    vecs[3] = '{16,   8'h57, 1'b1, 1'b0, 1'b1, 12'd100};
`else
    vecs[3] = '{16,   8'h57, 1'b1, 1'b1, 1'b0, 12'd20};
`endif
    vecs[4] = '{2000, 8'h55, 1'b0, 1'b1, 1'b0, 12'd2000};
    vecs[5] = '{17,   8'h55, 1'b0, 1'b1, 1'b0, 12'd17};

    // Reset with the line held low, then arm on the still-low line.
    rst_i = 1'b1;
    en_i  = 1'b0;
    rx_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cfg_div", 32'(cfg_div_o), 32'd868);
    check("reset_cfg_en",  32'(cfg_en_o),  32'd0);
    check("reset_lock",    32'(lock_o),    32'd0);
    check("reset_err",     32'(err_o),     32'd0);
    rst_i = 1'b0;
    en_i  = 1'b1;
    repeat (10) @(negedge clk);
    check("armed_low_lock", 32'(lock_o), 32'd0);
    check("armed_low_err",  32'(err_o),  32'd0);
    hold(1'b1, 20);
    sb.push_back('{1'b1, 1'b0, 12'd16});
    send_frame(16, 8'h55, 1'b0, 1'b1);
    wait_sb("reset_low_16clk");
    prev_div = 12'd16;

    foreach (vecs[v]) begin
      en_i = 1'b0;
      @(negedge clk);
      check("idle_lock",    32'(lock_o),    32'd0);
      check("idle_cfg_en",  32'(cfg_en_o),  32'd0);
      check("idle_err",     32'(err_o),     32'd0);
      check("idle_div_hold", 32'(cfg_div_o), 32'(prev_div));
      en_i = 1'b1;
      hold(1'b1, 3);
      sb.push_back('{vecs[v].exp_lock, vecs[v].exp_err, vecs[v].exp_div});
      send_frame(vecs[v].bit_clks, vecs[v].ch, vecs[v].extra, vecs[v].exp_lock);
      wait_sb($sformatf("vec%0d", v));
      prev_div = vecs[v].exp_div;
    end

    // Single falling edge, line stuck low: counter must saturate into ERROR.
    en_i = 1'b0;
    @(negedge clk);
    en_i = 1'b1;
    hold(1'b1, 3);
    sb.push_back('{1'b0, 1'b1, prev_div});
    rx_i = 1'b0;
    repeat (32767) @(negedge clk);
    check("stuck_err_early", 32'(err_o), 32'd0);
    @(negedge clk);
    check("stuck_err",    32'(err_o),     32'd1);
    check("stuck_cfg_en", 32'(cfg_en_o),  32'd0);
    check("stuck_div",    32'(cfg_div_o), 32'(prev_div));
    wait_sb("stuck_low");

    en_i = 1'b0;
    @(negedge clk);
    check("stuck_clear_err", 32'(err_o), 32'd0);
    en_i = 1'b1;
    hold(1'b0, 5);
    hold(1'b1, 5);
    sb.push_back('{1'b1, 1'b0, 12'd16});
    send_frame(16, 8'h55, 1'b0, 1'b1);
    wait_sb("rearm_16clk");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
